// File: rtl/multi_bowl_feeder.sv
// Multi-bowl pet feeder: keypad-programmed auto-feed intervals and manual pour/stop per bowl.
// Optional feature macro PF_EXCLUSIVE_POUR_EN serialises pours so at most one bowl is open.
module multi_bowl_feeder #(
  parameter int N_BOWLS    = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int INTERVAL_W = 16,
  parameter int POUR_S     = 5,
  parameter int SEL_W      = (N_BOWLS > 1) ? $clog2(N_BOWLS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         keyboard_option,
  input  logic               option_enable,
  input  logic [3:0]         keyboard_digit,
  input  logic               digit_enable,
  input  logic [SEL_W-1:0]   bowl_sel,
  output logic [N_BOWLS-1:0] food_switch,
  output logic               busy,
  output logic               err
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PC_W  = $clog2(POUR_S + 1);
  localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PC_W-1:0]       POUR_LOAD = PC_W'(POUR_S);
  localparam logic [INTERVAL_W-1:0] ENTRY_MAX = {INTERVAL_W{1'b1}};
  localparam logic [SEL_W:0]        NB_L      = (SEL_W + 1)'(N_BOWLS);

  localparam logic [2:0] OPT_IDLE     = 3'd0;
  localparam logic [2:0] OPT_POUR     = 3'd1;
  localparam logic [2:0] OPT_STOP     = 3'd2;
  localparam logic [2:0] OPT_INTERVAL = 3'd3;
  localparam logic [2:0] OPT_RESET    = 3'd4;

  // Decimal shift-in of one digit, clamped to the register range.
  function automatic logic [INTERVAL_W-1:0] entry_push(input logic [INTERVAL_W-1:0] base,
                                                       input logic [3:0] d);
    logic [INTERVAL_W+3:0] wide;
    wide = {4'b0000, base} * (INTERVAL_W + 4)'(10) + {{INTERVAL_W{1'b0}}, d};
    if (wide > {4'b0000, ENTRY_MAX}) begin
      return ENTRY_MAX;
    end else begin
      return wide[INTERVAL_W-1:0];
    end
  endfunction

  logic [PRE_W-1:0]      prescaler_r;
  logic                  tick_s;
  logic [INTERVAL_W-1:0] entry_r, entry_n;
  logic [PC_W-1:0]       pc_r [N_BOWLS];
  logic [PC_W-1:0]       pc_n [N_BOWLS];
  logic [INTERVAL_W-1:0] iv_r [N_BOWLS];
  logic [INTERVAL_W-1:0] iv_n [N_BOWLS];
  logic [INTERVAL_W-1:0] cd_r [N_BOWLS];
  logic [INTERVAL_W-1:0] cd_n [N_BOWLS];
  logic [N_BOWLS-1:0]    pour_mask_s, sel_onehot_s, fs_n;
  logic                  sel_ok_s, opt_known_s, cmd_s, cmd_eff_s, reject_s, digit_ok_s, err_n;
`ifdef PF_EXCLUSIVE_POUR_EN
  logic [N_BOWLS-1:0]    pend_r, pend_n, req_s, cand_s;
  logic                  granted_s;
`endif

  assign tick_s = (prescaler_r == PRE_LAST);

  // Command and digit validation; a bad bowl or unknown code only raises err.
  always_comb begin
    sel_ok_s     = ({1'b0, bowl_sel} < NB_L);
    opt_known_s  = (keyboard_option <= OPT_RESET);
    sel_onehot_s = sel_ok_s ? (N_BOWLS'(1) << bowl_sel) : '0;
    for (int b = 0; b < N_BOWLS; b++) begin
      pour_mask_s[b] = (pc_r[b] != '0);
    end
    cmd_s = option_enable && sel_ok_s && opt_known_s && (keyboard_option != OPT_IDLE);
`ifdef PF_EXCLUSIVE_POUR_EN
    reject_s = cmd_s && (keyboard_option == OPT_POUR) && ((pour_mask_s & ~sel_onehot_s) != '0);
`else
    reject_s = 1'b0;
`endif
    cmd_eff_s  = cmd_s && !reject_s;
    digit_ok_s = digit_enable && (keyboard_digit <= 4'd9);
    err_n = (digit_enable && !digit_ok_s) || (option_enable && !(sel_ok_s && opt_known_s)) || reject_s;
  end

  // Entry register: an INTERVAL in the same cycle consumes the old value first.
  always_comb begin
    if (digit_ok_s) begin
      if (cmd_eff_s && (keyboard_option == OPT_INTERVAL)) begin
        entry_n = entry_push('0, keyboard_digit);
      end else begin
        entry_n = entry_push(entry_r, keyboard_digit);
      end
    end else if (cmd_eff_s && (keyboard_option == OPT_INTERVAL)) begin
      entry_n = '0;
    end else begin
      entry_n = entry_r;
    end
  end

  // Per-bowl next state: a command on a bowl takes priority over that bowl's tick update.
  always_comb begin
`ifdef PF_EXCLUSIVE_POUR_EN
    req_s     = '0;
    pend_n    = pend_r;
    cand_s    = '0;
    granted_s = 1'b0;
`endif
    for (int b = 0; b < N_BOWLS; b++) begin
      pc_n[b] = pc_r[b];
      iv_n[b] = iv_r[b];
      cd_n[b] = cd_r[b];
      if (cmd_eff_s && (bowl_sel == SEL_W'(b))) begin
        case (keyboard_option)
          OPT_POUR: begin
            pc_n[b] = POUR_LOAD;
`ifdef PF_EXCLUSIVE_POUR_EN
            pend_n[b] = 1'b0;
`endif
          end
          OPT_STOP: begin
            pc_n[b] = '0;
`ifdef PF_EXCLUSIVE_POUR_EN
            pend_n[b] = 1'b0;
`endif
          end
          OPT_INTERVAL: begin
            iv_n[b] = entry_r;
            cd_n[b] = entry_r;
          end
          OPT_RESET: begin
            pc_n[b] = '0;
            iv_n[b] = '0;
            cd_n[b] = '0;
`ifdef PF_EXCLUSIVE_POUR_EN
            pend_n[b] = 1'b0;
`endif
          end
          default: pc_n[b] = pc_r[b];
        endcase
      end else if (tick_s) begin
        if (pc_r[b] != '0) begin
          pc_n[b] = pc_r[b] - PC_W'(1);
        end else begin
          pc_n[b] = pc_r[b];
        end
        if (cd_r[b] == INTERVAL_W'(1)) begin
          cd_n[b] = iv_r[b];
          // An expiry during an ongoing pour is dropped, not queued.
          if (pc_r[b] == '0) begin
`ifdef PF_EXCLUSIVE_POUR_EN
            req_s[b] = 1'b1;
`else
            pc_n[b] = POUR_LOAD;
`endif
          end else begin
            cd_n[b] = iv_r[b];
          end
        end else if (cd_r[b] != '0) begin
          cd_n[b] = cd_r[b] - INTERVAL_W'(1);
        end else begin
          cd_n[b] = cd_r[b];
        end
      end else begin
        pc_n[b] = pc_r[b];
      end
    end
`ifdef PF_EXCLUSIVE_POUR_EN
    // Grant the lowest waiting bowl only once every bowl is closed and no manual pour starts.
    cand_s = pend_n | req_s;
    if ((pour_mask_s == '0) && !(cmd_eff_s && (keyboard_option == OPT_POUR))) begin
      for (int b = 0; b < N_BOWLS; b++) begin
        if (cand_s[b] && !granted_s) begin
          pc_n[b]   = POUR_LOAD;
          cand_s[b] = 1'b0;
          granted_s = 1'b1;
        end else begin
          cand_s[b] = cand_s[b];
        end
      end
    end else begin
      granted_s = 1'b0;
    end
    pend_n = cand_s;
`endif
    for (int b = 0; b < N_BOWLS; b++) begin
      fs_n[b] = (pc_n[b] != '0);
    end
  end

  // State and registered outputs, all cleared by the synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_r <= '0;
      entry_r     <= '0;
      food_switch <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      for (int b = 0; b < N_BOWLS; b++) begin
        pc_r[b] <= '0;
        iv_r[b] <= '0;
        cd_r[b] <= '0;
      end
`ifdef PF_EXCLUSIVE_POUR_EN
      pend_r <= '0;
`endif
    end else begin
      prescaler_r <= tick_s ? '0 : prescaler_r + PRE_W'(1);
      entry_r     <= entry_n;
      food_switch <= fs_n;
      busy        <= |fs_n;
      err         <= err_n;
      for (int b = 0; b < N_BOWLS; b++) begin
        pc_r[b] <= pc_n[b];
        iv_r[b] <= iv_n[b];
        cd_r[b] <= cd_n[b];
      end
`ifdef PF_EXCLUSIVE_POUR_EN
      pend_r <= pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_multi_bowl_feeder.sv
// Directed bench for multi_bowl_feeder (TICK_DIV=4, POUR_S=3, N_BOWLS=4, 3-bit bowl_sel).
module tb_multi_bowl_feeder;
  localparam int NB = 4;
  localparam int SW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    keyboard_option;
  logic          option_enable;
  logic [3:0]    keyboard_digit;
  logic          digit_enable;
  logic [SW-1:0] bowl_sel;
  logic [NB-1:0] food_switch;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c, t1, exp_rise, rise1, rise2, hi_len, other_cnt, busy_bad, hi, p, base, r0, r1, both;
  logic prev;

  multi_bowl_feeder #(
    .N_BOWLS(NB), .TICK_DIV(4), .INTERVAL_W(16), .POUR_S(3), .SEL_W(SW)
  ) dut (
    .clock(clock), .reset(reset), .keyboard_option(keyboard_option),
    .option_enable(option_enable), .keyboard_digit(keyboard_digit),
    .digit_enable(digit_enable), .bowl_sel(bowl_sel), .food_switch(food_switch),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [SW-1:0] sel);
    keyboard_option = op;
    bowl_sel        = sel;
    option_enable   = 1'b1;
    step();
    option_enable   = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    keyboard_digit = d;
    digit_enable   = 1'b1;
    step();
    digit_enable   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; option_enable = 1'b0; digit_enable = 1'b0;
    keyboard_option = 3'd0; keyboard_digit = 4'd0; bowl_sel = '0;
    step(); step();
    reset = 1'b0; cyc = 0;
    check_val("rst_switch", 32'(food_switch), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);

    // interval 12 on bowl 2: expiry on the 12th tick after the command
    digit(4'd1); digit(4'd2);
    check_val("entry_12", 32'(dut.entry_r), 32'd12);
    cmd(3'd3, 3'd2);
    c = cyc;
    check_val("entry_clr", 32'(dut.entry_r), 32'd0);
    t1 = (c / 4 + 1) * 4;
    exp_rise = t1 + 44;
    rise1 = -1; rise2 = -1; hi_len = 0; other_cnt = 0; busy_bad = 0; prev = food_switch[2];
    while (cyc < exp_rise + 68) begin
      step();
      if (food_switch[2] && !prev) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (food_switch[2] && rise1 >= 0 && rise2 < 0) hi_len++;
      if (food_switch[0] || food_switch[1] || food_switch[3]) other_cnt++;
      if (busy !== (|food_switch)) busy_bad++;
      prev = food_switch[2];
    end
    check_val("auto_rise1", 32'(rise1), 32'(exp_rise));
    check_val("auto_rise2", 32'(rise2), 32'(exp_rise + 48));
    check_val("auto_len", 32'(hi_len), 32'd12);
    check_val("auto_others", 32'(other_cnt), 32'd0);
    check_val("auto_busy", 32'(busy_bad), 32'd0);

    // reset while bowl 1 pours and bowl 2 is armed
    cmd(3'd1, 3'd1);
    check_val("pour1_on", 32'(food_switch[1]), 32'd1);
    reset = 1'b1;
    step(); step();
    reset = 1'b0; cyc = 0;
    check_val("midrst_switch", 32'(food_switch), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_err", 32'(err), 32'd0);
    other_cnt = 0;
    repeat (80) begin
      step();
      if (food_switch != '0) other_cnt++;
    end
    check_val("no_auto_after_rst", 32'(other_cnt), 32'd0);

    // POUR bowl 0, STOP two cycles later
    hi = 0;
    cmd(3'd1, 3'd0);
    check_val("pour0_on", 32'(food_switch), 32'd1);
    check_val("pour0_busy", 32'(busy), 32'd1);
    hi += int'(food_switch[0]);
    step();
    hi += int'(food_switch[0]);
    cmd(3'd2, 3'd0);
    hi += int'(food_switch[0]);
    step();
    hi += int'(food_switch[0]);
    check_val("pour_stop_len", 32'(hi), 32'd2);
    check_val("stop_busy", 32'(busy), 32'd0);

    // full manual pour: open until the third tick after the command
    cmd(3'd1, 3'd1);
    p = cyc;
    t1 = (p / 4 + 1) * 4;
    hi = int'(food_switch[1]);
    repeat (16) begin
      step();
      hi += int'(food_switch[1]);
    end
    check_val("pour_len", 32'(hi), 32'(t1 + 8 - p));

`ifndef PF_EXCLUSIVE_POUR_EN
    cmd(3'd1, 3'd0);
    cmd(3'd1, 3'd3);
    check_val("indep_pour", 32'(food_switch), 32'd9);
    cmd(3'd2, 3'd0);
    cmd(3'd2, 3'd3);
    check_val("indep_stop", 32'(food_switch), 32'd0);
`endif

    // entry saturation and bad digit
    repeat (6) digit(4'd9);
    check_val("entry_sat", 32'(dut.entry_r), 32'd65535);
    check_val("sat_no_err", 32'(err), 32'd0);
    digit(4'hA);
    check_val("bad_digit_err", 32'(err), 32'd1);
    check_val("bad_digit_entry", 32'(dut.entry_r), 32'd65535);
    step();
    check_val("bad_digit_err_end", 32'(err), 32'd0);

    // unknown option and nonexistent bowl
    cmd(3'b111, 3'd0);
    check_val("opt7_err", 32'(err), 32'd1);
    check_val("opt7_switch", 32'(food_switch), 32'd0);
    step();
    check_val("opt7_err_end", 32'(err), 32'd0);
    cmd(3'd1, 3'd5);
    check_val("bowl5_err", 32'(err), 32'd1);
    check_val("bowl5_switch", 32'(food_switch), 32'd0);
    check_val("bowl5_busy", 32'(busy), 32'd0);

    // INTERVAL and digit in the same cycle
    keyboard_digit = 4'd7;
    digit_enable   = 1'b1;
    cmd(3'd3, 3'd3);
    digit_enable   = 1'b0;
    check_val("ivdig_entry", 32'(dut.entry_r), 32'd7);
    check_val("ivdig_iv", 32'(dut.iv_r[3]), 32'd65535);
    check_val("ivdig_err", 32'(err), 32'd0);
    cmd(3'd3, 3'd3);
    check_val("iv7_entry", 32'(dut.entry_r), 32'd0);
    check_val("iv7_iv", 32'(dut.iv_r[3]), 32'd7);
    cmd(3'd4, 3'd3);
    check_val("bowl_reset_iv", 32'(dut.iv_r[3]), 32'd0);

`ifdef PF_EXCLUSIVE_POUR_EN
    // bowls 0 and 1 expire on the same tick: bowl 0 first, bowl 1 after it closes
    while (cyc % 4 != 0) step();
    base = cyc;
    digit(4'd2);
    keyboard_digit = 4'd2;
    digit_enable   = 1'b1;
    cmd(3'd3, 3'd0);
    digit_enable   = 1'b0;
    cmd(3'd3, 3'd1);
    r0 = -1; r1 = -1; both = 0;
    repeat (80) begin
      step();
      if (food_switch[0] && food_switch[1]) both++;
      if (food_switch[0] && r0 < 0) r0 = cyc;
      if (food_switch[1] && r1 < 0) r1 = cyc;
    end
    check_val("excl_never_both", 32'(both), 32'd0);
    check_val("excl_first0", 32'(r0), 32'(base + 8));
    check_val("excl_then1", 32'(r1), 32'(base + 21));
    cmd(3'd4, 3'd0);
    cmd(3'd4, 3'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
